// File: rtl/snake_game_sequencer_if.sv
// Keyboard/datapath-facing signal bundle for the Snake game sequencer.
// pause_req exists only when SNAKE_SEQ_PAUSE_EN is defined.
interface snake_game_sequencer_if #(
    parameter int unsigned SCORE_W = 13
);
    logic [4:0]         number_input;
    logic [4:0]         direction;
    logic               frame_update;
    logic               good_collision;
    logic               bad_collision;
`ifdef SNAKE_SEQ_PAUSE_EN
    logic               pause_req;
`endif
    logic               inmenu;
    logic               ingame;
    logic               initial_head;
    logic               allow_moving;
    logic               move_step;
    logic               game_over;
    logic [3:0]         main_difficulty;
    logic [SCORE_W-1:0] score;

    modport slave (
        input  number_input, direction, frame_update, good_collision, bad_collision,
`ifdef SNAKE_SEQ_PAUSE_EN
        input  pause_req,
`endif
        output inmenu, ingame, initial_head, allow_moving, move_step, game_over,
        output main_difficulty, score
    );

    modport master (
        output number_input, direction, frame_update, good_collision, bad_collision,
`ifdef SNAKE_SEQ_PAUSE_EN
        output pause_req,
`endif
        input  inmenu, ingame, initial_head, allow_moving, move_step, game_over,
        input  main_difficulty, score
    );
endinterface

// File: rtl/snake_game_sequencer.sv
// Top-level Snake game FSM: menu, difficulty select, play pacing, score and game-over hold.
// Define SNAKE_SEQ_PAUSE_EN to add the pause_req input and the PAUSED state.
module snake_game_sequencer #(
    parameter int unsigned FRAME_DIV_W     = 4,
    parameter int unsigned GAMEOVER_FRAMES = 120,
    parameter int unsigned SCORE_W         = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    snake_game_sequencer_if.slave bus
);
    localparam int unsigned DIFF_W = 4;
    localparam int unsigned GO_W   = $clog2(GAMEOVER_FRAMES + 1);

    localparam logic [4:0] KEY1      = 5'b00010;
    localparam logic [4:0] KEY2      = 5'b00100;
    localparam logic [4:0] KEY3      = 5'b01000;
    localparam logic [4:0] DIR_UP    = 5'b00010;
    localparam logic [4:0] DIR_LEFT  = 5'b00100;
    localparam logic [4:0] DIR_DOWN  = 5'b01000;
    localparam logic [4:0] DIR_RIGHT = 5'b10000;

    typedef enum logic [2:0] {
        INIT      = 3'd0,
        MENU      = 3'd1,
        GAME_WAIT = 3'd2,
        INGAME    = 3'd3,
        GAME_OVER = 3'd4,
        PAUSED    = 3'd5
    } state_e;

    state_e                 state_q, state_d;
    logic [DIFF_W-1:0]      diff_q, diff_d;
    logic [FRAME_DIV_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [GO_W-1:0]        go_cnt_q, go_cnt_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic                   good_prev_q;
    logic                   move_step_q, move_step_d;
    logic                   inmenu_q, inmenu_d;
    logic                   ingame_q, ingame_d;
    logic                   initial_head_q, initial_head_d;
    logic                   allow_moving_q, allow_moving_d;
    logic                   game_over_q, game_over_d;
    logic                   good_edge_c;
    logic                   key_valid_c;
    logic                   dir_valid_c;
`ifdef SNAKE_SEQ_PAUSE_EN
    logic                   pause_prev_q;
    logic                   pause_edge_c;
    assign pause_edge_c = bus.pause_req & ~pause_prev_q;
`endif

    assign good_edge_c = bus.good_collision & ~good_prev_q;
    assign key_valid_c = (bus.number_input == KEY1) || (bus.number_input == KEY2) ||
                         (bus.number_input == KEY3);
    assign dir_valid_c = (bus.direction == DIR_UP) || (bus.direction == DIR_LEFT) ||
                         (bus.direction == DIR_DOWN) || (bus.direction == DIR_RIGHT);

    // Next state, counters and score; a collision always wins over apples and steps.
    always_comb begin
        state_d     = state_q;
        diff_d      = diff_q;
        frame_cnt_d = '0;
        go_cnt_d    = '0;
        score_d     = score_q;
        move_step_d = 1'b0;
        case (state_q)
            INIT: state_d = MENU;
            MENU: begin
                case (bus.number_input)
                    KEY1:    diff_d = DIFF_W'(4);
                    KEY2:    diff_d = DIFF_W'(2);
                    KEY3:    diff_d = DIFF_W'(1);
                    default: diff_d = diff_q;
                endcase
                if (key_valid_c) begin
                    state_d = GAME_WAIT;
                    score_d = '0;
                end
            end
            GAME_WAIT: if (dir_valid_c) state_d = INGAME;
            INGAME: begin
                frame_cnt_d = frame_cnt_q;
                if (bus.bad_collision) begin
                    state_d     = GAME_OVER;
                    frame_cnt_d = '0;
`ifdef SNAKE_SEQ_PAUSE_EN
                end else if (pause_edge_c) begin
                    state_d = PAUSED;
`endif
                end else begin
                    if (good_edge_c && (score_q != '1)) score_d = score_q + SCORE_W'(1);
                    if (bus.frame_update) begin
                        if (frame_cnt_q == FRAME_DIV_W'(diff_q)) begin
                            frame_cnt_d = '0;
                            move_step_d = 1'b1;
                        end else begin
                            frame_cnt_d = frame_cnt_q + FRAME_DIV_W'(1);
                        end
                    end
                end
            end
`ifdef SNAKE_SEQ_PAUSE_EN
            PAUSED: begin
                frame_cnt_d = frame_cnt_q;
                if (pause_edge_c) state_d = INGAME;
            end
`endif
            GAME_OVER: begin
                go_cnt_d = go_cnt_q;
                if (bus.frame_update) begin
                    if (go_cnt_q == GO_W'(GAMEOVER_FRAMES - 1)) begin
                        state_d  = MENU;
                        go_cnt_d = '0;
                    end else begin
                        go_cnt_d = go_cnt_q + GO_W'(1);
                    end
                end
            end
            default: state_d = INIT;
        endcase

        inmenu_d       = (state_d == MENU);
        ingame_d       = (state_d == GAME_WAIT) || (state_d == INGAME) ||
                         (state_d == GAME_OVER) || (state_d == PAUSED);
        initial_head_d = (state_d == GAME_WAIT);
        allow_moving_d = (state_d == INGAME);
        game_over_d    = (state_d == GAME_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= INIT;
            diff_q         <= DIFF_W'(1);
            frame_cnt_q    <= '0;
            go_cnt_q       <= '0;
            score_q        <= '0;
            good_prev_q    <= 1'b0;
            move_step_q    <= 1'b0;
            inmenu_q       <= 1'b0;
            ingame_q       <= 1'b0;
            initial_head_q <= 1'b0;
            allow_moving_q <= 1'b0;
            game_over_q    <= 1'b0;
`ifdef SNAKE_SEQ_PAUSE_EN
            pause_prev_q   <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            diff_q         <= diff_d;
            frame_cnt_q    <= frame_cnt_d;
            go_cnt_q       <= go_cnt_d;
            score_q        <= score_d;
            good_prev_q    <= bus.good_collision;
            move_step_q    <= move_step_d;
            inmenu_q       <= inmenu_d;
            ingame_q       <= ingame_d;
            initial_head_q <= initial_head_d;
            allow_moving_q <= allow_moving_d;
            game_over_q    <= game_over_d;
`ifdef SNAKE_SEQ_PAUSE_EN
            pause_prev_q   <= bus.pause_req;
`endif
        end
    end

    assign bus.inmenu          = inmenu_q;
    assign bus.ingame          = ingame_q;
    assign bus.initial_head    = initial_head_q;
    assign bus.allow_moving    = allow_moving_q;
    assign bus.move_step       = move_step_q;
    assign bus.game_over       = game_over_q;
    assign bus.main_difficulty = diff_q;
    assign bus.score           = score_q;
endmodule

// File: tb/tb_snake_game_sequencer.sv
// Directed plus random bench for snake_game_sequencer against a frame-count reference model.
module tb_snake_game_sequencer;
    localparam int SCORE_W = 13;
    localparam int GO_FRAMES = 120;
    localparam int SCORE_MAX = (1 << SCORE_W) - 1;

    localparam int P_INIT = 0, P_MENU = 1, P_WAIT = 2, P_PLAY = 3, P_OVER = 4, P_PAUSE = 5;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   steps;

    snake_game_sequencer_if #(.SCORE_W(SCORE_W)) bus ();

    snake_game_sequencer #(
        .FRAME_DIV_W(4),
        .GAMEOVER_FRAMES(GO_FRAMES),
        .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Reference model: phase, total play frames (step every diff+1), game-over frames
    int m_phase = P_INIT, m_diff = 1, m_score = 0, m_play = 0, m_over = 0;
    bit m_step = 0, m_gprev = 0, m_pprev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit gedge = bus.good_collision && !m_gprev;
        bit pedge = 1'b0;
        bit nstep = 1'b0;
`ifdef SNAKE_SEQ_PAUSE_EN
        pedge = bus.pause_req && !m_pprev;
        m_pprev = bus.pause_req;
`endif
        m_gprev = bus.good_collision;
        if (reset) begin
            m_phase = P_INIT; m_diff = 1; m_score = 0; m_play = 0; m_over = 0;
            m_step = 0; m_gprev = 0; m_pprev = 0;
            return;
        end
        case (m_phase)
            P_INIT: m_phase = P_MENU;
            P_MENU: begin
                if (bus.number_input == 5'b00010) m_diff = 4;
                else if (bus.number_input == 5'b00100) m_diff = 2;
                else if (bus.number_input == 5'b01000) m_diff = 1;
                if (bus.number_input inside {5'b00010, 5'b00100, 5'b01000}) begin
                    m_phase = P_WAIT;
                    m_score = 0;
                end
            end
            P_WAIT: if (bus.direction inside {5'b00010, 5'b00100, 5'b01000, 5'b10000}) begin
                m_phase = P_PLAY;
                m_play = 0;
            end
            P_PLAY: begin
                if (bus.bad_collision) begin
                    m_phase = P_OVER;
                    m_over = 0;
                end else if (pedge) begin
                    m_phase = P_PAUSE;
                end else begin
                    if (gedge && m_score < SCORE_MAX) m_score++;
                    if (bus.frame_update) begin
                        m_play++;
                        if (m_play % (m_diff + 1) == 0) nstep = 1;
                    end
                end
            end
            P_PAUSE: if (pedge) m_phase = P_PLAY;
            P_OVER: if (bus.frame_update) begin
                m_over++;
                if (m_over == GO_FRAMES) m_phase = P_MENU;
            end
            default: m_phase = P_INIT;
        endcase
        m_step = nstep;
    endtask

    function automatic logic [31:0] exp_vec();
        bit play_like = m_phase inside {P_WAIT, P_PLAY, P_OVER, P_PAUSE};
        return 32'({m_phase == P_MENU, play_like, m_phase == P_WAIT, m_phase == P_PLAY,
                    m_step, m_phase == P_OVER, 4'(m_diff), 13'(m_score)});
    endfunction

    function automatic logic [31:0] obs_vec();
        return 32'({bus.inmenu, bus.ingame, bus.initial_head, bus.allow_moving,
                    bus.move_step, bus.game_over, bus.main_difficulty, bus.score});
    endfunction

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("cycle", obs_vec(), exp_vec());
    endtask

    task automatic frame_pulse();
        bus.frame_update = 1'b1;
        cycle();
        bus.frame_update = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.number_input = '0;
        bus.direction = '0;
        bus.frame_update = 1'b0;
        bus.good_collision = 1'b0;
        bus.bad_collision = 1'b0;
`ifdef SNAKE_SEQ_PAUSE_EN
        bus.pause_req = 1'b0;
`endif
        repeat (3) cycle();
        chk("rst_inmenu", 32'(bus.inmenu), 0);
        chk("rst_ingame", 32'(bus.ingame), 0);
        chk("rst_diff", 32'(bus.main_difficulty), 1);
        chk("rst_score", 32'(bus.score), 0);

        reset = 1'b0;
        cycle();
        chk("menu_inmenu", 32'(bus.inmenu), 1);
        chk("menu_ingame", 32'(bus.ingame), 0);

        bus.number_input = 5'b00100;
        cycle();
        bus.number_input = '0;
        chk("wait_diff", 32'(bus.main_difficulty), 2);
        chk("wait_head", 32'(bus.initial_head), 1);
        chk("wait_ingame", 32'(bus.ingame), 1);

        cycle();
        bus.direction = 5'b10000;
        cycle();
        bus.direction = '0;
        chk("play_allow", 32'(bus.allow_moving), 1);
        chk("play_head", 32'(bus.initial_head), 0);

        steps = 0;
        for (int k = 1; k <= 9; k++) begin
            frame_pulse();
            chk($sformatf("step_f%0d", k), 32'(bus.move_step), 32'(k % 3 == 0));
            steps += int'(bus.move_step);
            repeat (9) begin
                cycle();
                steps += int'(bus.move_step);
            end
        end
        chk("step_count", 32'(steps), 3);

        bus.good_collision = 1'b1;
        repeat (5) cycle();
        bus.good_collision = 1'b0;
        chk("score_hold", 32'(bus.score), 1);
        repeat (2) cycle();
        bus.good_collision = 1'b1;
        cycle();
        bus.good_collision = 1'b0;
        cycle();
        chk("score_pulse", 32'(bus.score), 2);

        for (int i = 0; i < SCORE_MAX + 4; i++) begin
            bus.good_collision = 1'b1;
            cycle();
            bus.good_collision = 1'b0;
            cycle();
        end
        chk("score_sat", 32'(bus.score), 32'(SCORE_MAX));

        bus.good_collision = 1'b1;
        bus.bad_collision = 1'b1;
        cycle();
        bus.good_collision = 1'b0;
        bus.bad_collision = 1'b0;
        chk("bad_gameover", 32'(bus.game_over), 1);
        chk("bad_score", 32'(bus.score), 32'(SCORE_MAX));
        chk("bad_allow", 32'(bus.allow_moving), 0);

        for (int i = 0; i < GO_FRAMES - 1; i++) begin
            frame_pulse();
            cycle();
        end
        chk("over_hold", 32'(bus.game_over), 1);
        frame_pulse();
        chk("over_menu", 32'(bus.inmenu), 1);
        chk("over_score", 32'(bus.score), 32'(SCORE_MAX));

        bus.number_input = 5'b00010;
        cycle();
        bus.number_input = '0;
        chk("clr_score", 32'(bus.score), 0);
        chk("clr_diff", 32'(bus.main_difficulty), 4);

        bus.direction = 5'b00010;
        cycle();
        bus.direction = '0;
        repeat (4) begin
            frame_pulse();
            cycle();
        end
        reset = 1'b1;
        bus.frame_update = 1'b1;
        cycle();
        reset = 1'b0;
        bus.frame_update = 1'b0;
        chk("rst_mid_step", 32'(bus.move_step), 0);
        chk("rst_mid_ingame", 32'(bus.ingame), 0);
        chk("rst_mid_inmenu", 32'(bus.inmenu), 0);
        cycle();
        chk("rst_mid_menu", 32'(bus.inmenu), 1);

`ifdef SNAKE_SEQ_PAUSE_EN
        bus.number_input = 5'b01000;
        cycle();
        bus.number_input = '0;
        bus.direction = 5'b00100;
        cycle();
        bus.direction = '0;
        frame_pulse();
        bus.pause_req = 1'b1;
        cycle();
        bus.pause_req = 1'b0;
        chk("pause_ingame", 32'(bus.ingame), 1);
        chk("pause_allow", 32'(bus.allow_moving), 0);
        steps = 0;
        repeat (20) begin
            frame_pulse();
            steps += int'(bus.move_step);
            cycle();
        end
        chk("pause_steps", 32'(steps), 0);
        bus.pause_req = 1'b1;
        cycle();
        bus.pause_req = 1'b0;
        chk("resume_allow", 32'(bus.allow_moving), 1);
        frame_pulse();
        chk("resume_step", 32'(bus.move_step), 1);
`endif

        for (int i = 0; i < 6000; i++) begin
            reset = ($urandom_range(0, 799) == 0);
            bus.number_input = 5'(1 << $urandom_range(0, 5));
            bus.direction = 5'(1 << $urandom_range(0, 5));
            bus.frame_update = ($urandom_range(0, 2) == 0);
            bus.good_collision = ($urandom_range(0, 2) == 0);
            bus.bad_collision = ($urandom_range(0, 49) == 0);
`ifdef SNAKE_SEQ_PAUSE_EN
            bus.pause_req = ($urandom_range(0, 6) == 0);
`endif
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
